// File: rtl/cfg_cmd_sequencer_if.sv
// N64 register-file and CPU config-block signals of the command sequencer.
interface cfg_cmd_sequencer_if;
  logic        n64_cmd_valid;
  logic [7:0]  n64_cmd;
  logic [1:0]  n64_data_write;
  logic [31:0] n64_wdata;
  logic        n64_busy;
  logic        n64_done;
  logic        n64_error;
  logic [7:0]  cfg_cmd;
  logic        cfg_cmd_request;
  logic [31:0] cfg_data_0;
  logic [31:0] cfg_data_1;
  logic        cfg_cpu_ready;
  logic        cfg_cpu_busy;
  logic [1:0]  cfg_data_write;
  logic [31:0] cfg_wdata;

  modport slave (
    input  n64_cmd_valid, n64_cmd, n64_data_write, n64_wdata,
    input  cfg_cpu_ready, cfg_cpu_busy, cfg_data_write, cfg_wdata,
    output n64_busy, n64_done, n64_error,
    output cfg_cmd, cfg_cmd_request, cfg_data_0, cfg_data_1
  );

  modport master (
    output n64_cmd_valid, n64_cmd, n64_data_write, n64_wdata,
    output cfg_cpu_ready, cfg_cpu_busy, cfg_data_write, cfg_wdata,
    input  n64_busy, n64_done, n64_error,
    input  cfg_cmd, cfg_cmd_request, cfg_data_0, cfg_data_1
  );
endinterface

// File: rtl/cfg_cmd_sequencer.sv
// N64 -> CPU config command sequencer: request pulses the cycle after n64_cmd_valid; commands while busy
// or CPU not ready are dropped and flagged on n64_error. CFG_CMD_TIMEOUT_EN adds WAIT_ACK/WAIT_DONE timeouts.
module cfg_cmd_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFF_FFFF
) (
  input logic               clk,
  input logic               reset,
  input logic               n64_soft_reset,
  cfg_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK, WAIT_DONE} state_t;

  state_t state;
  logic   cpu_window;

  assign cpu_window = (state == WAIT_ACK) || (state == WAIT_DONE);

`ifdef CFG_CMD_TIMEOUT_EN
  logic [23:0] timer;
  logic        timed_out;
  assign timed_out = (timer == TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      bus.n64_busy        <= 1'b0;
      bus.n64_done        <= 1'b0;
      bus.n64_error       <= 1'b0;
      bus.cfg_cmd         <= 8'h00;
      bus.cfg_cmd_request <= 1'b0;
      bus.cfg_data_0      <= 32'h0;
      bus.cfg_data_1      <= 32'h0;
`ifdef CFG_CMD_TIMEOUT_EN
      timer               <= 24'd0;
`endif
    end else if (n64_soft_reset) begin
      // Abort in flight; command byte and data words deliberately survive.
      state               <= IDLE;
      bus.n64_busy        <= 1'b0;
      bus.n64_done        <= 1'b0;
      bus.n64_error       <= 1'b0;
      bus.cfg_cmd_request <= 1'b0;
`ifdef CFG_CMD_TIMEOUT_EN
      timer               <= 24'd0;
`endif
    end else begin
      bus.cfg_cmd_request <= 1'b0;
      bus.n64_done        <= 1'b0;

      if (state == IDLE) begin
        if (bus.n64_data_write[0]) bus.cfg_data_0 <= bus.n64_wdata;
        if (bus.n64_data_write[1]) bus.cfg_data_1 <= bus.n64_wdata;
      end else if (cpu_window) begin
        if (bus.cfg_data_write[0]) bus.cfg_data_0 <= bus.cfg_wdata;
        if (bus.cfg_data_write[1]) bus.cfg_data_1 <= bus.cfg_wdata;
      end

      if (bus.n64_cmd_valid && (state != IDLE)) bus.n64_error <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.n64_cmd_valid) begin
            if (bus.cfg_cpu_ready) begin
              bus.cfg_cmd         <= bus.n64_cmd;
              bus.cfg_cmd_request <= 1'b1;
              bus.n64_busy        <= 1'b1;
              bus.n64_error       <= 1'b0;
              state               <= REQUEST;
            end else begin
              bus.n64_error <= 1'b1;
            end
          end
        end
        REQUEST: begin
          state <= WAIT_ACK;
`ifdef CFG_CMD_TIMEOUT_EN
          timer <= 24'd0;
`endif
        end
        WAIT_ACK: begin
          if (bus.cfg_cpu_busy) begin
            state <= WAIT_DONE;
`ifdef CFG_CMD_TIMEOUT_EN
            timer <= 24'd0;
          end else if (timed_out) begin
            state         <= IDLE;
            bus.n64_busy  <= 1'b0;
            bus.n64_error <= 1'b1;
          end else begin
            timer <= timer + 24'd1;
`endif
          end
        end
        WAIT_DONE: begin
          if (!bus.cfg_cpu_busy) begin
            state        <= IDLE;
            bus.n64_busy <= 1'b0;
            bus.n64_done <= 1'b1;
`ifdef CFG_CMD_TIMEOUT_EN
          end else if (timed_out) begin
            state         <= IDLE;
            bus.n64_busy  <= 1'b0;
            bus.n64_error <= 1'b1;
          end else begin
            timer <= timer + 24'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
